// File: rtl/updown_mod_counter.sv
// updown_mod_counter: prescaled up/down modulo-M counter with load, wrap or saturate, Tick and TC strobes
module updown_mod_counter #(
    parameter int N   = 8,
    parameter int M   = 256,
    parameter int P   = 1,
    parameter int SAT = 0
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         En,
    input  logic         Up,
    input  logic         Load,
    input  logic [N-1:0] D,
    output logic [N-1:0] Q,
    output logic         Tick,
    output logic         TC
);
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam logic [N-1:0] QMAX = N'(M - 1);
    localparam logic [PW-1:0] PMAX = PW'(P - 1);
    logic [PW-1:0] pcnt;
    logic          step;
    logic          at_top;
    logic          at_bot;
    logic [N-1:0]  q_up;
    logic [N-1:0]  q_dn;
    logic [N-1:0]  q_ld;
    always_comb begin
        step   = En && (pcnt == PMAX);
        at_top = (Q == QMAX);
        at_bot = (Q == '0);
        q_up   = at_top ? ((SAT != 0) ? Q : '0) : Q + N'(1);
        q_dn   = at_bot ? ((SAT != 0) ? Q : QMAX) : Q - N'(1);
        q_ld   = (D > QMAX) ? QMAX : D;
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Q    <= '0;
            pcnt <= '0;
            Tick <= 1'b0;
            TC   <= 1'b0;
        end else if (Load) begin
            Q    <= q_ld;
            pcnt <= '0;
            Tick <= 1'b0;
            TC   <= 1'b0;
        end else begin
            Q    <= step ? (Up ? q_up : q_dn) : Q;
            pcnt <= step ? '0 : (En ? pcnt + PW'(1) : pcnt);
            Tick <= step;
            TC   <= step && (Up ? at_top : at_bot);
        end
    end
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: three counter configurations checked against an arithmetic reference model
module tb_updown_mod_counter;
    localparam int M = 10;
    localparam int PS [3] = '{1, 3, 3};
    localparam int SS [3] = '{0, 0, 1};
    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       En    = 1'b0;
    logic       Up    = 1'b1;
    logic       Load  = 1'b0;
    logic [3:0] D     = '0;
    logic [3:0] dq [3];
    logic       dt [3];
    logic       dc [3];
    int         mq [3];
    int         mp [3];
    int         mt [3];
    int         mc [3];
    bit         armed = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;
    always #5 Clock = ~Clock;
    updown_mod_counter #(.N(4), .M(M), .P(1), .SAT(0)) u_a (
        .Clock(Clock), .Reset(Reset), .En(En), .Up(Up), .Load(Load), .D(D),
        .Q(dq[0]), .Tick(dt[0]), .TC(dc[0]));
    updown_mod_counter #(.N(4), .M(M), .P(3), .SAT(0)) u_b (
        .Clock(Clock), .Reset(Reset), .En(En), .Up(Up), .Load(Load), .D(D),
        .Q(dq[1]), .Tick(dt[1]), .TC(dc[1]));
    updown_mod_counter #(.N(4), .M(M), .P(3), .SAT(1)) u_c (
        .Clock(Clock), .Reset(Reset), .En(En), .Up(Up), .Load(Load), .D(D),
        .Q(dq[2]), .Tick(dt[2]), .TC(dc[2]));
    task automatic chk(input string name, input int inst, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d at %0t: got %0d expected %0d", name, inst, $time, act, exp);
        end
    endtask
    // Reference: the count lives on 0..M-1; the prescaler counts enabled cycles modulo P.
    always @(posedge Clock) begin
        if (Reset) armed <= 1'b1;
        for (int i = 0; i < 3; i++) begin
            automatic bit st = En && (mp[i] + 1 == PS[i]);
            automatic bit edge_hit = Up ? (mq[i] == M - 1) : (mq[i] == 0);
            automatic int nq;
            if (Up) nq = SS[i] != 0 ? ((mq[i] + 1 > M - 1) ? M - 1 : mq[i] + 1) : (mq[i] + 1) % M;
            else    nq = SS[i] != 0 ? ((mq[i] - 1 < 0) ? 0 : mq[i] - 1) : (mq[i] + M - 1) % M;
            if (Reset) begin
                mq[i] <= 0; mp[i] <= 0; mt[i] <= 0; mc[i] <= 0;
            end else if (Load) begin
                mq[i] <= (int'(D) >= M) ? M - 1 : int'(D);
                mp[i] <= 0; mt[i] <= 0; mc[i] <= 0;
            end else begin
                mq[i] <= st ? nq : mq[i];
                mp[i] <= st ? 0 : (En ? mp[i] + 1 : mp[i]);
                mt[i] <= int'(st);
                mc[i] <= int'(st && edge_hit);
            end
        end
    end
    always @(negedge Clock) begin
        if (armed) begin
            for (int i = 0; i < 3; i++) begin
                chk("q", i, 32'(dq[i]), mq[i]);
                chk("tick", i, 32'(dt[i]), mt[i]);
                chk("tc", i, 32'(dc[i]), mc[i]);
            end
        end
    end
    task automatic cycles(input int n);
        repeat (n) @(posedge Clock);
        @(negedge Clock);
        #1;
    endtask
    initial begin
        cycles(2);
        chk("lit_reset_q", 0, 32'(dq[0]), 0);
        chk("lit_reset_tick", 1, 32'(dt[1]), 0);
        Reset = 1'b0; En = 1'b1; Up = 1'b1;
        cycles(9);
        chk("lit_up_q9", 0, 32'(dq[0]), 9);
        chk("lit_up_tc_low", 0, 32'(dc[0]), 0);
        cycles(1);
        chk("lit_wrap_q", 0, 32'(dq[0]), 0);
        chk("lit_wrap_tc", 0, 32'(dc[0]), 1);
        chk("lit_pre_q", 1, 32'(dq[1]), 3);
        Load = 1'b1; D = 4'd15;
        cycles(1);
        chk("lit_clamp", 2, 32'(dq[2]), 9);
        chk("lit_load_tick", 1, 32'(dt[1]), 0);
        Load = 1'b0;
        cycles(3);
        chk("lit_sat_q", 2, 32'(dq[2]), 9);
        chk("lit_sat_tc", 2, 32'(dc[2]), 1);
        chk("lit_wrap_after", 0, 32'(dq[0]), 2);
        Reset = 1'b1; Load = 1'b1; D = 4'd5;
        cycles(1);
        chk("lit_rst_load", 1, 32'(dq[1]), 0);
        Reset = 1'b0; Load = 1'b0; Up = 1'b0;
        cycles(1);
        chk("lit_down_q", 0, 32'(dq[0]), 9);
        chk("lit_down_tc", 0, 32'(dc[0]), 1);
        En = 1'b0;
        cycles(5);
        chk("lit_hold_q", 2, 32'(dq[2]), 0);
        En = 1'b1;
        cycles(2);
        chk("lit_sat0_tc", 2, 32'(dc[2]), 1);
        chk("lit_down_q7", 0, 32'(dq[0]), 7);
        for (int k = 0; k < 3000; k++) begin
            Reset = ($urandom_range(0, 63) == 0);
            Load  = ($urandom_range(0, 15) == 0);
            En    = ($urandom_range(0, 3) != 0);
            Up    = ($urandom_range(0, 2) != 0) ^ (k[9] == 1'b1);
            D     = 4'($urandom_range(0, 15));
            cycles(1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised up/down modulo counter with a built-in prescaler, synchronous load, and selectable wrap or saturate behaviour. It generalises the board-level free-running LED counter into a reusable core for timers, clock dividers and event counters in the DE-series demos. Top-level wrappers map `CLOCK_50`, KEY and SW onto its inputs, and map `Q`, `Tick` and `TC` onto LEDR or HEX displays.

## Interface
- `N`, default 8: counter width in bits.
- `M`, default 256: modulus; the count range is 0..M-1. Legal range 2 ≤ M ≤ 2^N.
- `P`, default 1: prescale factor; the count steps once per P enabled cycles. Legal range P ≥ 1.
- `SAT`, default 0: 0 = wrap at the bounds; 1 = saturate at the bounds.
- `Clock` in 1: single clock, rising edge. The top level drives it from `CLOCK_50`.
- `Reset` in 1: synchronous, active-high reset.
- `En` in 1: count enable; gates the prescaler.
- `Up` in 1: direction; 1 = increment, 0 = decrement. Sampled on step cycles only.
- `Load` in 1: synchronous load of `D`.
- `D` in N: load value.
- `Q` out N: current count, registered.
- `Tick` out 1: registered one-cycle strobe marking a step.
- `TC` out 1: registered one-cycle terminal-count strobe.

## Operation
- **Internal prescaler.** Internal register `pcnt`, width max(1, clog2(P)), range 0..P-1.
- **Priority each cycle.** Reset > Load > step > hold.
- **Reset.** Sets Q=0, pcnt=0, Tick=0, TC=0.
- **Load.**
  - Q ← min(D, M-1); values of D ≥ M are clamped to M-1.
  - pcnt ← 0; Tick ← 0; TC ← 0.
  - `En` is ignored during a load cycle.
- **Step condition.** A step occurs when En=1 and pcnt == P-1. With P=1, every enabled cycle is a step.
- **Prescaler.**
  - On a step: pcnt ← 0.
  - En=1 without a step: pcnt ← pcnt+1.
  - En=0: pcnt holds, so a partially counted prescale interval is not lost.
- **Step with Up=1.**
  - Q < M-1: Q ← Q+1.
  - Q == M-1: Q ← 0 if SAT=0; Q holds at M-1 if SAT=1.
- **Step with Up=0.**
  - Q > 0: Q ← Q-1.
  - Q == 0: Q ← M-1 if SAT=0; Q holds at 0 if SAT=1.
- **Tick.** Tick ← 1 on every step cycle, otherwise 0.
- **TC.**
  - TC ← 1 on a step taken from the boundary value: Q == M-1 with Up=1, or Q == 0 with Up=0. This holds for both SAT settings.
  - Otherwise TC ← 0.
  - With SAT=1 and En held at a bound, TC pulses once per step for as long as that continues.
- **Direction changes.** Changing `Up` between steps has no effect on pcnt. Only the value sampled on the step cycle matters.
- **Arithmetic.** All compares are at N bits against the constants M-1 and 0. There is no overflow beyond M-1, because Q never exceeds M-1 after reset or load.
- **State machine.** None beyond pcnt; the block is a pure counter datapath.

## Timing
- **Registered outputs.** Q, Tick and TC all update on the same rising edge. Tick and TC are high during the cycle in which Q already shows the post-step value.
- **Latency.**
  - Input sampled at edge k gives the result at edge k.
  - En rising: the first step occurs P cycles later, counting from the current pcnt.
  - Load or Reset: the value is visible at the next edge.
  - After a load, the first step needs P enabled cycles.
- **Outputs during Reset.** Q=0, Tick=0, TC=0 in the cycle after Reset is sampled high, and they stay there while Reset is held.
- **Reset mid-interval.** The prescaler is discarded; there is no partial credit.
- **Simultaneous Reset+Load.** Reset wins.
- **Simultaneous Load+step-condition.** Load wins; no Tick and no TC are produced.

## Test plan
- **Up wrap.** N=4, M=10, P=1, SAT=0, Reset then En=1, Up=1 for 12 cycles.
  - Q follows 1,2,…,9,0,1,2.
  - TC is high exactly in the cycle Q=0.
  - Tick is high every cycle.
- **Down wrap.** Same config, Up=0 from Q=0.
  - Q follows 9,8,7.
  - TC is high in the cycle Q=9.
- **Prescale.** M=10, P=3, Up=1.
  - Q increments every 3rd enabled cycle; Tick is high 1 cycle in 3.
  - Drop En for 5 cycles mid-interval: Q and pcnt hold, and the step resumes after the remaining enabled cycles.
- **Saturate.** SAT=1, M=10.
  - Load D=8, Up=1: Q becomes 9, then stays 9; TC pulses on each step at 9.
  - Up=0 down to 0: Q holds at 0, and TC pulses on each step at 0.
- **Load.**
  - Load D=4 with P=3 at pcnt=2: Q=4, no Tick, next step 3 enabled cycles later.
  - Load D=15 with M=10: Q=9.
  - Load and Reset both high: Q=0.
- **Reset mid-count.** Assert Reset at Q=6 with pcnt=1.
  - Next cycle: Q=0, Tick=0, TC=0.
  - Release: the first step occurs after P enabled cycles.
